// File: rtl/mux16.sv
// Two-input word multiplexer with a combinational result and a registered
// copy of that result, the select, and a one-cycle change pulse.
module mux16 #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             s,
  output logic [WIDTH-1:0] OUT,
  output logic [WIDTH-1:0] OUT_R,
  output logic             SEL_R,
  output logic             CHG
);

  // Same-cycle result for downstream datapath logic; independent of clk/reset.
  assign OUT = s ? Y : X;

  // Registered stage; CHG compares the incoming value with the pre-update OUT_R.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      OUT_R <= '0;
      SEL_R <= 1'b0;
      CHG   <= 1'b0;
    end else begin
      OUT_R <= OUT;
      SEL_R <= s;
      CHG   <= (OUT != OUT_R);
    end
  end

endmodule

// File: tb/tb_mux16.sv
// Self-checking bench for mux16: directed steps followed by random stimulus,
// compared against a capture-history reference model.
module tb_mux16;

  localparam int unsigned WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] X;
  logic [WIDTH-1:0] Y;
  logic             s;
  logic [WIDTH-1:0] OUT;
  logic [WIDTH-1:0] OUT_R;
  logic             SEL_R;
  logic             CHG;

  int checks = 0;
  int errors = 0;

  // Reference state: last captured word, last captured select, change flag.
  logic [WIDTH-1:0] m_out_r;
  logic             m_sel_r;
  logic             m_chg;

  mux16 #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .X     (X),
    .Y     (Y),
    .s     (s),
    .OUT   (OUT),
    .OUT_R (OUT_R),
    .SEL_R (SEL_R),
    .CHG   (CHG)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [WIDTH-1:0] pick(input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b,
                                            input logic sel);
    if (sel) return b;
    return a;
  endfunction

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs,
                     input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_comb(input string tag);
    chk({tag, "_out"}, OUT, pick(X, Y, s));
  endtask

  task automatic check_regs(input string tag);
    chk({tag, "_out_r"}, OUT_R, m_out_r);
    chk({tag, "_sel_r"}, WIDTH'(SEL_R), WIDTH'(m_sel_r));
    chk({tag, "_chg"},   WIDTH'(CHG),   WIDTH'(m_chg));
  endtask

  task automatic model_reset();
    m_out_r = '0;
    m_sel_r = 1'b0;
    m_chg   = 1'b0;
  endtask

  // Advance one rising edge, updating the model from the inputs it will capture.
  task automatic tick(input string tag);
    logic [WIDTH-1:0] cap;
    if (!rst_n) begin
      model_reset();
    end else begin
      cap     = pick(X, Y, s);
      m_chg   = (cap != m_out_r);
      m_out_r = cap;
      m_sel_r = s;
    end
    @(posedge clk);
    #1;
    check_regs(tag);
    check_comb(tag);
  endtask

  initial begin
    rst_n = 1'b0;
    X = '0;
    Y = '0;
    s = 1'b0;
    model_reset();

    // Reset state with zero operands.
    #2;
    check_comb("rst_zero");
    check_regs("rst_zero");

    // OUT follows inputs while reset holds the registers.
    X = WIDTH'(1234);
    #1;
    chk("rst_x1234_out", OUT, WIDTH'(1234));
    check_regs("rst_x1234");
    @(posedge clk);
    #1;
    check_regs("rst_hold_edge");

    // Static select.
    X = WIDTH'(255); Y = '0; s = 1'b0;
    #1;
    chk("static_s0", OUT, WIDTH'(255));
    s = 1'b1;
    #1;
    chk("static_s1", OUT, WIDTH'(0));

    // Operand swap patterns every 5 time units.
    X = WIDTH'(511); Y = WIDTH'(63); s = 1'b0; #5; chk("swap_p0", OUT, WIDTH'(511));
    s = 1'b1;                                  #5; chk("swap_p1", OUT, WIDTH'(63));
    X = WIDTH'(63); Y = WIDTH'(511); s = 1'b0; #5; chk("swap_p2", OUT, WIDTH'(63));
    s = 1'b1;                                  #5; chk("swap_p3", OUT, WIDTH'(511));
    check_regs("swap_regs");

    // Release reset between edges; registered path with s toggling.
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    X = WIDTH'(511); Y = WIDTH'(63); s = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick($sformatf("toggle%0d", i));
      s = ~s;
    end

    // Identical operands: only the first capture differs.
    X = 16'hA5A5; Y = 16'hA5A5;
    for (int i = 0; i < 5; i++) begin
      tick($sformatf("same%0d", i));
      s = ~s;
    end

    // Capture 511 (CHG pulse) then reset mid-cycle.
    X = WIDTH'(511); s = 1'b0;
    tick("pre_async");
    chk("pre_async_chg_high", WIDTH'(CHG), WIDTH'(1));
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_regs("async_rst");
    check_comb("async_rst");
    tick("async_hold");
    #2;
    rst_n = 1'b1;
    tick("post_release");

    // Random operands/select with occasional equal operands and reset pulses.
    for (int i = 0; i < 300; i++) begin
      X = WIDTH'($urandom);
      if ($urandom_range(0, 7) == 0) Y = X;
      else Y = WIDTH'($urandom);
      s = 1'($urandom_range(0, 1));
      #1;
      check_comb("rnd_comb");
      if ($urandom_range(0, 31) == 0) begin
        rst_n = 1'b0;
        #1;
        model_reset();
        check_regs("rnd_rst");
        rst_n = 1'b1;
      end
      tick("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
